// File: rtl/ahb_console_uart_if.sv
// AHB-Lite slave-side bus bundle for the console UART window.
interface ahb_console_uart_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_console_uart.sv
// AHB-Lite console slave: putc/hex-print stores -> byte FIFO -> 8N1 serial output.
// state      | meaning
// EXP_IDLE   | no hex expansion pending
// EXP_EXPAND | pushing one ASCII char per cycle, index 0..7 nibbles, 8 newline
// TX_IDLE    | line high, waiting for a byte
// TX_START   | start bit low for div cycles
// TX_DATA    | 8 data bits, LSB first, div cycles each
// TX_STOP    | stop bit high for div cycles
module ahb_console_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CLK_DIV    = 16'd434
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_console_uart_if.slave ahb,
  output logic              uart_tx,
  output logic              tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HEX    = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  typedef enum logic {EXP_IDLE, EXP_EXPAND} exp_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic       dph_valid_q, dph_valid_d;
  logic       dph_write_q, dph_write_d;
  logic [1:0] dph_reg_q, dph_reg_d;
  logic [15:0] div_q, div_d;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  exp_state_e  exp_state_q, exp_state_d;
  logic [31:0] exp_shift_q, exp_shift_d;
  logic [3:0]  exp_idx_q, exp_idx_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic        uart_tx_q, uart_tx_d;

  logic fifo_full, fifo_empty, exp_busy;
  logic wr_data, wr_hex, wr_div, stall;
  logic data_push, hex_load, exp_push, push_en, pop_en;
  logic [7:0] exp_char, push_byte, rd_byte;
  logic unused_bus;

  assign unused_bus = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0], BASE_ADDR};

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'b0, nib}) : (8'h37 + {4'b0, nib});
  endfunction

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign exp_busy   = (exp_state_q == EXP_EXPAND);
  assign rd_byte    = fifo_mem_q[rd_ptr_q];

  assign wr_data = dph_valid_q & dph_write_q & (dph_reg_q == REG_DATA);
  assign wr_hex  = dph_valid_q & dph_write_q & (dph_reg_q == REG_HEX);
  assign wr_div  = dph_valid_q & dph_write_q & (dph_reg_q == REG_DIV);

  // DATA must also wait for the expander so bytes land in bus order
  assign stall     = (wr_data & (fifo_full | exp_busy)) | (wr_hex & exp_busy);
  assign data_push = wr_data & ~stall;
  assign hex_load  = wr_hex & ~exp_busy;

  assign ahb.HREADYOUT = ~stall;
  assign ahb.HRESP     = 1'b0;
  assign uart_tx       = uart_tx_q;
  assign tx_busy       = (tx_state_q != TX_IDLE) | ~fifo_empty;

  always_comb begin
    ahb.HRDATA = '0;
    if (dph_valid_q && !dph_write_q) begin
      case (dph_reg_q)
        REG_STATUS: ahb.HRDATA = {16'b0, 8'(count_q), 5'b0, tx_busy, fifo_empty, fifo_full};
        REG_DIV:    ahb.HRDATA = {16'b0, div_q};
        default:    ahb.HRDATA = '0;
      endcase
    end
  end

  always_comb begin
    dph_valid_d = dph_valid_q;
    dph_write_d = dph_write_q;
    dph_reg_d   = dph_reg_q;
    if (ahb.HREADY) begin
      dph_valid_d = ahb.HSEL & ahb.HTRANS[1];
      dph_write_d = ahb.HWRITE;
      dph_reg_d   = ahb.HADDR[3:2];
    end
    div_d = div_q;
    if (wr_div) div_d = (ahb.HWDATA[15:0] == 16'd0) ? 16'd1 : ahb.HWDATA[15:0];
  end

  always_comb begin
    exp_state_d = exp_state_q;
    exp_shift_d = exp_shift_q;
    exp_idx_d   = exp_idx_q;
    exp_push    = 1'b0;
    exp_char    = (exp_idx_q == 4'd8) ? 8'h0A : hex_ascii(exp_shift_q[31:28]);
    case (exp_state_q)
      EXP_IDLE: begin
        if (hex_load) begin
          exp_shift_d = ahb.HWDATA;
          exp_idx_d   = 4'd0;
          exp_state_d = EXP_EXPAND;
        end
      end
      EXP_EXPAND: begin
        if (!fifo_full) begin
          exp_push    = 1'b1;
          exp_shift_d = {exp_shift_q[27:0], 4'h0};
          exp_idx_d   = exp_idx_q + 4'd1;
          if (exp_idx_q == 4'd8) exp_state_d = EXP_IDLE;
        end
      end
      default: exp_state_d = EXP_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    pop_en     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop_en     = 1'b1;
          tx_shift_d = rd_byte;
          tx_div_d   = div_q;
          tx_cnt_d   = div_q - 16'd1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop_en     = 1'b1;
            tx_shift_d = rd_byte;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // line is registered from the next state so it never glitches
    case (tx_state_d)
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = tx_shift_d[0];
      default:  uart_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    push_en   = exp_push | data_push;
    push_byte = exp_push ? exp_char : ahb.HWDATA[7:0];
    wr_ptr_d  = push_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_en ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d   = count_q + CW'(push_en) - CW'(pop_en);
  end

  always_ff @(posedge HCLK) begin
    if (push_en) fifo_mem_q[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_reg_q   <= 2'd0;
      div_q       <= CLK_DIV;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      exp_state_q <= EXP_IDLE;
      exp_shift_q <= '0;
      exp_idx_q   <= 4'd0;
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= 3'd0;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= CLK_DIV;
      uart_tx_q   <= 1'b1;
    end else begin
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      dph_reg_q   <= dph_reg_d;
      div_q       <= div_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      exp_state_q <= exp_state_d;
      exp_shift_q <= exp_shift_d;
      exp_idx_q   <= exp_idx_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      uart_tx_q   <= uart_tx_d;
    end
  end
endmodule
